// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Instructions are word aligned; the low two byte-address bits must be zero.
  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return pc_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small output FIFO between memory fetch and decode; flush empties it at once.
module fetch_fifo #(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Pop needs data; push needs space unless a pop frees a slot on the same edge.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != FULL_CNT) || do_pop);
  end

  // Storage array; contents only matter while counted, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches instruction words for each accepted PC over a req/ack memory port and
// queues {instr, pc} for decode. Flush abandons buffered and in-flight fetches.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc,
  input  logic               pc_valid,
  input  logic               flush,
  output logic               fetch_stall,
  output logic               mem_req,
  output logic [PC_W-3:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               fetch_err
);

  localparam int unsigned TCNT_W  = $clog2(TIMEOUT+1);
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = INSTR_W + PC_W;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  fetch_state_t        state_q;
  logic                mem_req_q;
  logic [PC_W-3:0]     mem_addr_q;
  logic [PC_W-1:0]     pc_q;
  logic [TCNT_W-1:0]   tcnt_q;
  logic                err_q;

  logic                accept;
  logic                fifo_push, fifo_pop;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic [CNT_W-1:0]    fifo_count;

  // Only one fetch is ever outstanding and it is issued from IDLE, so a FIFO that
  // is not full at issue time always has room for the returning word.
  always_comb begin
    fetch_stall = rst || (state_q != IDLE) || (fifo_count == FULL_CNT);
    accept      = pc_valid && !fetch_stall && !flush;
    fifo_push   = (state_q == WAIT) && mem_ack && !flush;
    fifo_pop    = instr_valid && instr_ready;
  end

  // Fetch FSM with registered memory request, address/pc latch, timeout and error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pc_q       <= '0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (pc_aligned(pc[1:0])) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc[PC_W-1:2];
              pc_q       <= pc;
              tcnt_q     <= '0;
              state_q    <= WAIT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WAIT, DISCARD: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            tcnt_q    <= '0;
            state_q   <= IDLE;
          end else begin
            // Request stays up until acked even when discarding.
            if (state_q == WAIT && flush) state_q <= DISCARD;
            if (tcnt_q != TCNT_MAX) tcnt_q <= tcnt_q + 1'b1;
            if (tcnt_q == TCNT_LAST) err_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({mem_rdata, pc_q}),
    .pop   (fifo_pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  // Head is presented as NOP/0 while empty so outputs are defined after reset.
  always_comb begin
    instr_valid = (fifo_count != '0);
    instr       = instr_valid ? fifo_rdata[ENTRY_W-1:PC_W] : NOP;
    instr_pc    = instr_valid ? fifo_rdata[PC_W-1:0] : '0;
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign fetch_err = err_q;

endmodule
